// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one unsigned eq/gt/lt comparator among NREQ requesters.
// Define CMP_ARB_COUNT_EN to add the saturating cmp_count completed-compare counter.
module cmp_share_arbiter #(
  parameter  int NREQ = 4,
  parameter  int W    = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_eq,
  output logic              rsp_gt,
  output logic              rsp_lt
`ifdef CMP_ARB_COUNT_EN
  ,
  output logic [15:0]       cmp_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_RESP
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic           eq_q, eq_d;
  logic           gt_q, gt_d;
  logic           lt_q, lt_d;
  logic           vld_q, vld_d;

  logic           found;
  logic [IDW-1:0] win;
  int             idx;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    x_d       = x_q;
    y_d       = y_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    vld_d     = vld_q;
    req_ready = '0;
    unique case (state_q)
      S_IDLE: begin
        if (rst_n && found) begin
          req_ready[win] = 1'b1;
          x_d     = req_x[int'(win)*W +: W];
          y_d     = req_y[int'(win)*W +: W];
          id_d    = win;
          ptr_d   = win;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        eq_d    = (x_q == y_q);
        gt_d    = (x_q > y_q);
        lt_d    = (x_q < y_q);
        vld_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      vld_q   <= vld_d;
    end
  end

  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_eq    = eq_q;
  assign rsp_gt    = gt_q;
  assign rsp_lt    = lt_q;

`ifdef CMP_ARB_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (vld_q && rsp_ready && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cmp_count = cnt_q;
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_cmp_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_eq;
  logic              rsp_gt;
  logic              rsp_lt;
`ifdef CMP_ARB_COUNT_EN
  logic [15:0]       cmp_count;
`endif

  int checks = 0;
  int errors = 0;

  cmp_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_eq    (rsp_eq),
    .rsp_gt    (rsp_gt),
    .rsp_lt    (rsp_lt)
`ifdef CMP_ARB_COUNT_EN
    ,
    .cmp_count (cmp_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = NREQ'($urandom);
      req_x     = (NREQ*W)'($urandom);
      req_y     = (NREQ*W)'($urandom);
      rsp_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ready: got %b want 0000", req_ready);
      end
      checks++;
      if ({rsp_valid, rsp_eq, rsp_gt, rsp_lt} !== 4'b0000 || rsp_id !== 2'd0) begin
        errors++;
        $display("FAIL reset_rsp: got v%b e%b g%b l%b id%0d want all 0",
                 rsp_valid, rsp_eq, rsp_gt, rsp_lt, rsp_id);
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_x[3:0] = 4'd9;
    req_y[3:0] = 4'd3;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: rsp_valid got %b want 0 at T+1", rsp_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 ||
        {rsp_eq, rsp_gt, rsp_lt} !== 3'b010) begin
      errors++;
      $display("FAIL single_rsp: got v%b id%0d egl%b%b%b want v1 id0 egl010",
               rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || {rsp_eq, rsp_gt, rsp_lt} !== 3'b000) begin
      errors++;
      $display("FAIL single_clear: got v%b egl%b%b%b want 0 000",
               rsp_valid, rsp_eq, rsp_gt, rsp_lt);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    req_x     = {4{4'd5}};
    req_y     = {4{4'd5}};
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'(1 << (g % 4))) begin
        errors++;
        $display("FAIL fair_grant%0d: got %b want %b", g, req_ready, 4'(1 << (g % 4)));
      end
      tick();
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL fair_cmp%0d: ready %b valid %b want 0000 0", g, req_ready, rsp_valid);
      end
      tick();
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(g % 4) || rsp_eq !== 1'b1 ||
          req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL fair_rsp%0d: v%b id%0d eq%b ready %b want v1 id%0d eq1 0000",
                 g, rsp_valid, rsp_id, rsp_eq, req_ready, g % 4);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    req_x[11:8] = 4'd2;
    req_y[11:8] = 4'd7;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_grant: got %b want 0100", req_ready);
    end
    tick();
    req_valid = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 ||
          {rsp_eq, rsp_gt, rsp_lt} !== 3'b001 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold%0d: v%b id%0d egl%b%b%b ready %b want v1 id2 001 0000",
                 i, rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release: v%b ready %b want v0 ready 1000", rsp_valid, req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    req_x[7:4] = 4'd1;
    req_y[7:4] = 4'd1;
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL mid_reset%0d: v%b ready %b want 0 0000", i, rsp_valid, req_ready);
      end
      tick();
    end
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_regrant: ready %b v%b want 0001 0", req_ready, rsp_valid);
    end
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL mid_rsp: v%b id%0d want v1 id0", rsp_valid, rsp_id);
    end
    tick();
  endtask

  task automatic test_random();
    int       last;
    int       age;
    bit       busy;
    int       eid;
    int       w;
    bit       fnd;
    logic [3:0] ex, ey;
    logic [3:0] exp_ready;
    logic       exp_rv;
    do_reset();
    last = NREQ - 1;
    busy = 0;
    age  = 0;
    eid  = 0;
    ex   = '0;
    ey   = '0;
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      req_x     = (NREQ*W)'($urandom);
      req_y     = (NREQ*W)'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      exp_ready = '0;
      exp_rv    = 1'b0;
      fnd       = 0;
      w         = 0;
      if (!busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!fnd && req_valid[(last + k) % NREQ]) begin
            fnd = 1;
            w   = (last + k) % NREQ;
          end
        end
        if (fnd) exp_ready[w] = 1'b1;
      end else if (age >= 2) begin
        exp_rv = 1'b1;
      end
      checks++;
      if (req_ready !== exp_ready || rsp_valid !== exp_rv) begin
        errors++;
        $display("FAIL rnd_hs c%0d: ready %b v%b want %b v%b",
                 c, req_ready, rsp_valid, exp_ready, exp_rv);
      end
      checks++;
      if (exp_rv) begin
        if (rsp_id !== 2'(eid) || rsp_eq !== (ex == ey) ||
            rsp_gt !== (ex > ey) || rsp_lt !== (ex < ey)) begin
          errors++;
          $display("FAIL rnd_rsp c%0d: id%0d egl%b%b%b want id%0d x%0d y%0d",
                   c, rsp_id, rsp_eq, rsp_gt, rsp_lt, eid, ex, ey);
        end
      end else if ({rsp_eq, rsp_gt, rsp_lt} !== 3'b000) begin
        errors++;
        $display("FAIL rnd_flags c%0d: egl%b%b%b want 000", c, rsp_eq, rsp_gt, rsp_lt);
      end
      if (!busy) begin
        if (fnd) begin
          busy = 1;
          age  = 1;
          eid  = w;
          last = w;
          ex   = req_x[w*W +: W];
          ey   = req_y[w*W +: W];
        end
      end else if (age >= 2 && rsp_ready) begin
        busy = 0;
      end else begin
        age++;
      end
      tick();
    end
  endtask

`ifdef CMP_ARB_COUNT_EN
  task automatic test_count();
    do_reset();
    @(negedge clk);
    checks++;
    if (cmp_count !== 16'd0) begin
      errors++;
      $display("FAIL cnt_reset: got %0d want 0", cmp_count);
    end
    tick();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    for (int i = 0; i < 9; i++) tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    checks++;
    if (cmp_count !== 16'd3) begin
      errors++;
      $display("FAIL cnt_three: got %0d want 3", cmp_count);
    end
    tick();
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (cmp_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_sat: got %h want ffff", cmp_count);
    end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef CMP_ARB_COUNT_EN
    test_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
